// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_conditioner                                              |
// | Description : Push-button front end. Each channel is synchronised,         |
// |               debounced and edge-detected into a one-cycle command strobe, |
// |               with optional hold-to-repeat.                                |
// |               Optional feature macro: BTN_AUTO_REPEAT_EN                   |
// |                 defined   -> IDLE/DELAY/REPEAT auto-repeat per channel     |
// |                 undefined -> one pulse per press (rising edge of level)    |
// | Ports       : clk       - system clock, rising edge                        |
// |               rst       - asynchronous reset, ACTIVE-LOW                   |
// |               btn_raw   - [N_BTN] raw async button levels, active-high     |
// |               btn_level - [N_BTN] debounced registered level               |
// |               btn_pulse - [N_BTN] one-cycle press/repeat strobe            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,        // active-low
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int c_DW = $clog2(DEBOUNCE_CYCLES);

`ifdef BTN_AUTO_REPEAT_EN
    // One timer serves both the initial delay and the repeat period, so it is
    // sized for the larger of the two terminal counts.
    localparam int c_TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_TW      = $clog2(c_TMR_MAX);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DELAY  = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;
`endif

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic            r_sync1;
        logic            r_sync2;
        logic            r_level;
        logic            r_pulse;
        logic [c_DW-1:0] r_cnt;
        logic            w_done;
        logic            w_rise;
        logic            w_pulse_nxt;

        // The level flips on the same edge the counter would reach its
        // terminal value, giving DEBOUNCE_CYCLES consecutive mismatching
        // samples before acceptance.
        assign w_done = (r_sync2 != r_level) && (r_cnt == c_DW'(DEBOUNCE_CYCLES - 1));
        assign w_rise = w_done & r_sync2;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_sync1 <= btn_raw[i];
                r_sync2 <= r_sync1;
                // Any sample matching the accepted level restarts the count,
                // so a single-cycle bounce discards all progress.
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (w_done) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_pulse <= w_pulse_nxt;
            end
        end

`ifdef BTN_AUTO_REPEAT_EN
        logic            w_fall;
        logic [1:0]      r_state;
        logic [1:0]      w_state_nxt;
        logic [c_TW-1:0] r_tmr;
        logic [c_TW-1:0] w_tmr_nxt;

        assign w_fall = w_done & ~r_sync2;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= c_ST_IDLE;
                r_tmr   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_tmr   <= w_tmr_nxt;
            end
        end

        // Release takes priority over timer expiry: no strobe on the
        // release edge.
        always_comb begin
            w_state_nxt = r_state;
            w_tmr_nxt   = r_tmr;
            w_pulse_nxt = 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    w_tmr_nxt = '0;
                    if (w_rise) begin
                        w_pulse_nxt = 1'b1;
                        w_state_nxt = c_ST_DELAY;
                    end
                end
                c_ST_DELAY: begin
                    if (w_fall) begin
                        w_state_nxt = c_ST_IDLE;
                        w_tmr_nxt   = '0;
                    end else if (r_tmr == c_TW'(REPEAT_DELAY - 1)) begin
                        w_pulse_nxt = 1'b1;
                        w_tmr_nxt   = '0;
                        w_state_nxt = c_ST_REPEAT;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
                c_ST_REPEAT: begin
                    if (w_fall) begin
                        w_state_nxt = c_ST_IDLE;
                        w_tmr_nxt   = '0;
                    end else if (r_tmr == c_TW'(REPEAT_PERIOD - 1)) begin
                        w_pulse_nxt = 1'b1;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_tmr_nxt   = '0;
                end
            endcase
        end
`else
        assign w_pulse_nxt = w_rise;
`endif

        assign btn_level[i] = r_level;
        assign btn_pulse[i] = r_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_btn_conditioner                                           |
// | Description : Directed self-checking bench for btn_conditioner with        |
// |               DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=4.|
// |               Edge k below is the k-th rising edge after the stimulus      |
// |               change; outputs are sampled 1 time unit after each edge.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_btn_conditioner;

    localparam int c_N  = 4;
    localparam int c_DB = 4;
    localparam int c_RD = 10;
    localparam int c_RP = 3;

    logic           clk;
    logic           rst;
    logic [c_N-1:0] btn_raw;
    logic [c_N-1:0] btn_level;
    logic [c_N-1:0] btn_pulse;

    int n_vec;
    int n_err;

    btn_conditioner #(
        .N_BTN          (c_N),
        .DEBOUNCE_CYCLES(c_DB),
        .REPEAT_DELAY   (c_RD),
        .REPEAT_PERIOD  (c_RP)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_l;
        logic [3:0] exp_p;
        rst     = 1'b0;
        btn_raw = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (btn_level !== 4'h0 || btn_pulse !== 4'h0) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d level=%h pulse=%h exp level=0 pulse=0", k, btn_level, btn_pulse);
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_l = (k >= 5) ? 4'hF : 4'h0;
            exp_p = (k == 5) ? 4'hF : 4'h0;
            n_vec++;
            if (btn_level !== exp_l || btn_pulse !== exp_p) begin
                n_err++;
                $display("FAIL reset_release edge=%0d level=%h pulse=%h exp level=%h pulse=%h", k, btn_level, btn_pulse, exp_l, exp_p);
            end
        end
        // Asynchronous assertion between clock edges must clear at once.
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (btn_level !== 4'h0 || btn_pulse !== 4'h0) begin
            n_err++;
            $display("FAIL reset_async level=%h pulse=%h exp level=0 pulse=0", btn_level, btn_pulse);
        end
        btn_raw = 4'h0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_l;
        logic [3:0] exp_p;
        btn_raw = 4'h1;
        for (int k = 0; k < 21; k++) begin
            if (k == 8) btn_raw = 4'h0;
            tick();
            exp_l = (k >= 5 && k < 13) ? 4'h1 : 4'h0;
            exp_p = (k == 5) ? 4'h1 : 4'h0;
            n_vec++;
            if (btn_level !== exp_l || btn_pulse !== exp_p) begin
                n_err++;
                $display("FAIL clean_press edge=%0d level=%h pulse=%h exp level=%h pulse=%h", k, btn_level, btn_pulse, exp_l, exp_p);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_l;
        logic [3:0] exp_p;
        // Samples 1,1,1,0,1 then high: final rising sample at edge 4.
        for (int k = 0; k < 13; k++) begin
            btn_raw = (k == 3) ? 4'h0 : 4'h2;
            tick();
            exp_l = (k >= 9) ? 4'h2 : 4'h0;
            exp_p = (k == 9) ? 4'h2 : 4'h0;
            n_vec++;
            if (btn_level !== exp_l || btn_pulse !== exp_p) begin
                n_err++;
                $display("FAIL bounce_press edge=%0d level=%h pulse=%h exp level=%h pulse=%h", k, btn_level, btn_pulse, exp_l, exp_p);
            end
        end
        btn_raw = 4'h0;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_l = (k < 5) ? 4'h2 : 4'h0;
            n_vec++;
            if (btn_level !== exp_l || btn_pulse !== 4'h0) begin
                n_err++;
                $display("FAIL bounce_release edge=%0d level=%h pulse=%h exp level=%h pulse=0", k, btn_level, btn_pulse, exp_l);
            end
        end
    endtask

`ifdef BTN_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        logic [3:0] exp_l;
        logic [3:0] exp_p;
        // Held for samples 0..39; fall edge 45 coincides with a timer expiry.
        btn_raw = 4'h4;
        for (int k = 0; k < 52; k++) begin
            if (k == 40) btn_raw = 4'h0;
            tick();
            exp_l = (k >= 5 && k < 45) ? 4'h4 : 4'h0;
            exp_p = (k == 5 || (k >= 15 && k < 45 && ((k - 15) % 3) == 0)) ? 4'h4 : 4'h0;
            n_vec++;
            if (btn_level !== exp_l || btn_pulse !== exp_p) begin
                n_err++;
                $display("FAIL auto_repeat edge=%0d level=%h pulse=%h exp level=%h pulse=%h", k, btn_level, btn_pulse, exp_l, exp_p);
            end
        end
    endtask
`else
    task automatic test_no_repeat();
        logic [3:0] exp_l;
        logic [3:0] exp_p;
        btn_raw = 4'h4;
        for (int k = 0; k < 52; k++) begin
            if (k == 40) btn_raw = 4'h0;
            tick();
            exp_l = (k >= 5 && k < 45) ? 4'h4 : 4'h0;
            exp_p = (k == 5) ? 4'h4 : 4'h0;
            n_vec++;
            if (btn_level !== exp_l || btn_pulse !== exp_p) begin
                n_err++;
                $display("FAIL no_repeat edge=%0d level=%h pulse=%h exp level=%h pulse=%h", k, btn_level, btn_pulse, exp_l, exp_p);
            end
        end
    endtask
`endif

    task automatic test_simultaneous();
        logic [3:0] exp_l;
        logic [3:0] exp_p;
        btn_raw = 4'h9;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_l = (k >= 5) ? 4'h9 : 4'h0;
            exp_p = (k == 5) ? 4'h9 : 4'h0;
            n_vec++;
            if (btn_level !== exp_l || btn_pulse !== exp_p) begin
                n_err++;
                $display("FAIL simultaneous edge=%0d level=%h pulse=%h exp level=%h pulse=%h", k, btn_level, btn_pulse, exp_l, exp_p);
            end
        end
        btn_raw = 4'h0;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_l = (k < 5) ? 4'h9 : 4'h0;
            n_vec++;
            if (btn_level !== exp_l || btn_pulse !== 4'h0) begin
                n_err++;
                $display("FAIL simultaneous_release edge=%0d level=%h pulse=%h exp level=%h pulse=0", k, btn_level, btn_pulse, exp_l);
            end
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        btn_raw = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
`ifdef BTN_AUTO_REPEAT_EN
        test_auto_repeat();
`else
        test_no_repeat();
`endif
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
